in_port_ctrl: RTL and testbench
===============================

# in_port_ctrl

Sequencer for the execute-stage input-select mux of the 8-bit RISC core. It buffers bytes from an external input device in a small FIFO and services IN instructions. For each IN it drives the mux select `ie` and the byte on `data_in` for exactly one cycle, and it stalls the pipeline while no byte is available. It sits between the external device handshake and the writeback-path input mux.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in bytes; power of two, 2 to 16.
- `TIMEOUT`, 255: WAIT-state cycle limit; used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ext_data`  in  8  byte from the external device.
- `ext_valid`  in  1  device offers `ext_data`.
- `ext_ready`  out  1  FIFO can accept a byte.
- `in_req`  in  1  decoded IN instruction in execute; held high until `in_ack`.
- `ie`  out  1  input-mux select; 1 selects `data_in` over `Bus_D`.
- `data_in`  out  8  delivered byte.
- `in_ack`  out  1  `data_in` is valid this cycle; the register file writes it.
- `stall`  out  1  freeze PC and pipeline registers.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.
- `timeout_err`  out  1  one-cycle pulse when a timed-out IN completes. Tied 0 when the timeout feature is compiled out.

## Operation
- A push happens when `ext_valid && ext_ready`. `ext_ready = (fifo_count != DEPTH)` is combinational from the registered count.
- The FSM has three states: IDLE, WAIT, DELIVER.
  - IDLE: if `in_req` and count>0, pop the head into `data_in` and go to DELIVER. If `in_req` and count==0, go to WAIT. Otherwise stay.
  - WAIT: when count>0, pop the head into `data_in` and go to DELIVER.
  - DELIVER: assert `ie=1` and `in_ack=1`, then go to IDLE unconditionally.
- `stall` is combinational: `(IDLE && in_req) || WAIT`. It is 0 in DELIVER.
- `ie` and `in_ack` are high only in DELIVER. `data_in` holds the last delivered byte otherwise.
- Push and pop in the same cycle leave the count unchanged. A byte pushed in the same cycle it would be needed is not bypassed: it becomes visible the next cycle.
- A back-to-back IN (`in_req` still high in the cycle after DELIVER) is treated as a new request from IDLE.
- Pointers wrap modulo DEPTH. Count saturation cannot occur because pushes are blocked when full.

## Timing
- Reset values: state=IDLE, FIFO empty, `fifo_count=0`, `data_in=8'h00`, `ie=0`, `in_ack=0`, `stall=0`, `ext_ready=1`, `timeout_err=0`.
- Data present: `in_req` rises in cycle N, and `ie`/`in_ack` are high in cycle N+1. Latency is 1 and `stall` is high for one cycle.
- FIFO empty: a push accepted in cycle M while in WAIT gives DELIVER in cycle M+2.
- Throughput: one IN per 2 cycles at best.
- An asserted `rst_n` takes effect immediately in any state. It discards FIFO contents and any pending IN, and deasserts `stall`.

## Configuration
- `IN_PORT_TIMEOUT_EN` defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If WAIT lasts TIMEOUT cycles, the FSM goes to DELIVER with `data_in=8'hFF` and no pop, and `timeout_err` pulses in that DELIVER cycle.
- `IN_PORT_TIMEOUT_EN` undefined:
  - WAIT persists indefinitely.
  - No counter is instantiated and `timeout_err` is constant 0.

## Structure
- Shared package `in_port_pkg`: FSM state enum (IDLE, WAIT, DELIVER), `DATA_W=8`, and `TIMEOUT_FILL=8'hFF`.
- Sub-module `in_fifo`: synchronous byte FIFO with push, pop, head, count, and full/empty flags, and asynchronous active-low reset. The FSM and timeout logic live in `in_port_ctrl`.

## Test plan
- **Reset:** hold `rst_n=0` with traffic on all inputs. All outputs stay at their reset values and `ext_ready=1`.
- **Buffered IN:** push 8'hA5, then raise `in_req`. One cycle later `ie=1`, `in_ack=1`, `data_in=8'hA5`. `stall` is high for 1 cycle and `fifo_count` returns to 0.
- **Empty IN:** raise `in_req` with the FIFO empty and push 8'h3C after 5 cycles. `stall` stays high until DELIVER, which occurs 2 cycles after the push, with `data_in=8'h3C`.
- **Full/wrap:** push 8'h01..8'h04 with DEPTH=4. `ext_ready=0` and an offered 8'h05 is not accepted. Then run 6 INs while pushing 8'h05..8'h06. Delivery order is 01..06 with no loss.
- **Simultaneous push and pop:** count=2, push during the IDLE→DELIVER pop. Count stays 2 and the order is preserved.
- **Timeout** (`IN_PORT_TIMEOUT_EN` defined, TIMEOUT=8): IN with no data. After 8 WAIT cycles, DELIVER has `data_in=8'hFF` and a one-cycle `timeout_err` pulse, and the FIFO is untouched.

Source files
------------

// File: rtl/in_port_pkg.sv
// +----------------------------------------------------------------------+
// | in_port_pkg : shared types and constants for the IN-port sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package in_port_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] TIMEOUT_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/in_fifo.sv
// +----------------------------------------------------------------------+
// | in_fifo : synchronous byte FIFO with occupancy count and flags       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module in_fifo
  import in_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       push_data,
  output logic [DATA_W-1:0]       head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_count = (c_aw + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == c_full_count);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/in_port_ctrl.sv
// +----------------------------------------------------------------------+
// | in_port_ctrl : IN-instruction sequencer for the execute input mux    |
// | Optional WAIT timeout enabled by macro IN_PORT_TIMEOUT_EN.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module in_port_ctrl
  import in_port_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       ext_data,
  input  logic                    ext_valid,
  output logic                    ext_ready,
  input  logic                    in_req,
  output logic                    ie,
  output logic [DATA_W-1:0]       data_in,
  output logic                    in_ack,
  output logic                    stall,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    timeout_err
);

  state_e            r_state;
  state_e            w_next;
  logic              w_pop;
  logic              w_fill;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] r_data_in;

  in_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ext_valid && ext_ready),
    .pop       (w_pop),
    .push_data (ext_data),
    .head      (w_head),
    .count     (fifo_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign ext_ready = !w_full;

`ifdef IN_PORT_TIMEOUT_EN
  localparam int c_tw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_tw-1:0] c_wait_last = c_tw'(TIMEOUT - 1);

  logic [c_tw-1:0] r_wait_cnt;
  logic            r_timed_out;
  logic            w_expired;

  assign w_expired = (r_wait_cnt == c_wait_last);

  // Held at zero outside WAIT, so it always starts from zero on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_wait_cnt  <= (r_state == ST_WAIT) ? r_wait_cnt + 1'b1 : '0;
      r_timed_out <= w_fill;
    end
  end

  assign timeout_err = r_timed_out;
`else
  logic w_expired;
  assign w_expired   = 1'b0;
  // TIMEOUT has no effect in this build; the expression is constant zero.
  assign timeout_err = (TIMEOUT < 0);
`endif

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_fill = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_req) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = ST_DELIVER;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_DELIVER;
        end else if (w_expired) begin
          w_fill = 1'b1;
          w_next = ST_DELIVER;
        end
      end
      ST_DELIVER: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_data_in <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop)       r_data_in <= w_head;
      else if (w_fill) r_data_in <= TIMEOUT_FILL;
    end
  end

  assign data_in = r_data_in;
  assign ie      = (r_state == ST_DELIVER);
  assign in_ack  = (r_state == ST_DELIVER);
  // Gated by rst_n so a held in_req cannot stall the pipeline during reset.
  assign stall   = rst_n && (((r_state == ST_IDLE) && in_req) || (r_state == ST_WAIT));

endmodule

`default_nettype wire

// File: tb/tb_in_port_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_in_port_ctrl : directed self-checking bench for in_port_ctrl      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_in_port_ctrl;

  localparam int DEPTH = 4;
`ifdef IN_PORT_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ext_data = 8'h00;
  logic       ext_valid = 1'b0;
  logic       ext_ready;
  logic       in_req = 1'b0;
  logic       ie;
  logic [7:0] data_in;
  logic       in_ack;
  logic       stall;
  logic [2:0] fifo_count;
  logic       timeout_err;

  in_port_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ext_data    (ext_data),
    .ext_valid   (ext_valid),
    .ext_ready   (ext_ready),
    .in_req      (in_req),
    .ie          (ie),
    .data_in     (data_in),
    .in_ack      (in_ack),
    .stall       (stall),
    .fifo_count  (fifo_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       req;
    logic       e_ie;
    logic       e_stall;
    logic       e_ready;
    logic [2:0] e_cnt;
    logic [7:0] e_din;
  } vec_t;

  vec_t tbl [13];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_ie, input logic e_stall,
                          input logic e_ready, input logic [2:0] e_cnt,
                          input logic [7:0] e_din, input logic e_terr);
    chk({tag, ".ie"},          ie,          e_ie);
    chk({tag, ".in_ack"},      in_ack,      e_ie);
    chk({tag, ".stall"},       stall,       e_stall);
    chk({tag, ".ext_ready"},   ext_ready,   e_ready);
    chk({tag, ".fifo_count"},  fifo_count,  e_cnt);
    chk({tag, ".data_in"},     data_in,     e_din);
    chk({tag, ".timeout_err"}, timeout_err, e_terr);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_in(input string name, input logic [7:0] exp);
    int k;
    bit got;
    k   = 0;
    got = 1'b0;
    next_cycle();
    in_req    = 1'b1;
    ext_valid = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      if (in_ack) got = 1'b1;
      else begin
        next_cycle();
        k++;
      end
    end
    chk({name, ".ack"}, 32'(got), 32'd1);
    if (got) chk(name, data_in, exp);
  endtask

  initial begin
    logic [7:0] wrap_exp [6];
    int acks, pushed, cycles;

    // ext_valid, data, in_req | ie/ack, stall, ready, count, data_in
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'hA5};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hA5};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hA5};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hA5};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hA5};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hA5};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hA5};
    tbl[9]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hA5};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'hA5};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'h3C};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h3C};

    // Reset held with traffic on every input
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      ext_valid = 1'b1;
      ext_data  = 8'(8'h70 + i);
      in_req    = 1'b1;
      @(negedge clk);
      chk_outs("reset", 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
    end
    next_cycle();
    ext_valid = 1'b0;
    in_req    = 1'b0;
    rst_n     = 1'b1;

    // Buffered IN, then empty IN with a late push
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      ext_valid = tbl[i].v;
      ext_data  = tbl[i].d;
      in_req    = tbl[i].req;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), tbl[i].e_ie, tbl[i].e_stall, tbl[i].e_ready,
               tbl[i].e_cnt, tbl[i].e_din, 1'b0);
    end

    // Fill to DEPTH; a fifth offer must be refused
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      ext_valid = 1'b1;
      ext_data  = 8'(i + 1);
      in_req    = 1'b0;
    end
    next_cycle();
    ext_data = 8'h05;
    @(negedge clk);
    chk("full.ext_ready", ext_ready, 1'b0);
    chk("full.count", fifo_count, 3'd4);
    next_cycle();
    ext_valid = 1'b0;
    @(negedge clk);
    chk("full.hold_count", fifo_count, 3'd4);

    // Six back-to-back INs while 05 and 06 are pushed across the wrap
    wrap_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    acks   = 0;
    pushed = 5;
    cycles = 0;
    while (acks < 6 && cycles < 60) begin
      next_cycle();
      in_req    = 1'b1;
      ext_valid = (pushed <= 6);
      ext_data  = 8'(pushed);
      @(negedge clk);
      if (ext_valid && ext_ready) pushed++;
      if (in_ack) begin
        chk($sformatf("wrap.order%0d", acks), data_in, wrap_exp[acks]);
        acks++;
      end
      cycles++;
    end
    chk("wrap.acks", acks, 6);
    chk("wrap.pushed", pushed, 7);
    next_cycle();
    in_req    = 1'b0;
    ext_valid = 1'b0;
    @(negedge clk);
    chk("wrap.empty", fifo_count, 3'd0);

    // Push during the IDLE->DELIVER pop keeps the count
    next_cycle();
    ext_valid = 1'b1;
    ext_data  = 8'h11;
    next_cycle();
    ext_data  = 8'h22;
    next_cycle();
    ext_data  = 8'h33;
    in_req    = 1'b1;
    @(negedge clk);
    chk("sim.count_before", fifo_count, 3'd2);
    chk("sim.stall", stall, 1'b1);
    next_cycle();
    ext_valid = 1'b0;
    @(negedge clk);
    chk("sim.ack", in_ack, 1'b1);
    chk("sim.data", data_in, 8'h11);
    chk("sim.count_after", fifo_count, 3'd2);
    do_in("sim.second", 8'h22);
    do_in("sim.third", 8'h33);
    next_cycle();
    in_req = 1'b0;
    @(negedge clk);
    chk("sim.empty", fifo_count, 3'd0);

    // Asynchronous reset mid-cycle discards contents and drops stall
    next_cycle();
    ext_valid = 1'b1;
    ext_data  = 8'hAA;
    next_cycle();
    ext_data  = 8'hAB;
    next_cycle();
    ext_valid = 1'b0;
    next_cycle();
    in_req = 1'b1;
    @(negedge clk);
    chk("areset.pre_count", fifo_count, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.count", fifo_count, 3'd0);
    chk("areset.stall", stall, 1'b0);
    chk("areset.data_in", data_in, 8'h00);
    next_cycle();
    in_req = 1'b0;
    rst_n  = 1'b1;

`ifdef IN_PORT_TIMEOUT_EN
    // IN on an empty FIFO expires after TIMEOUT WAIT cycles
    next_cycle();
    in_req = 1'b1;
    @(negedge clk);
    chk("tmo.idle_stall", stall, 1'b1);
    for (int i = 0; i < TIMEOUT; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("tmo.wait%0d", i), {ie, stall, timeout_err}, 3'b010);
    end
    next_cycle();
    @(negedge clk);
    chk_outs("tmo.deliver", 1'b1, 1'b0, 1'b1, 3'd0, 8'hFF, 1'b1);
    next_cycle();
    in_req = 1'b0;
    @(negedge clk);
    chk("tmo.pulse_end", timeout_err, 1'b0);
    chk("tmo.fifo", fifo_count, 3'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
